fetch_sequencer: RTL

Fetch-stage controller that drives the `inc` / `branch_en` / `halt` / `branch_addr` controls of the 11-bit program counter. It arbitrates redirect, stall and halt requests from the hazard unit and execute stage, and inserts post-redirect bubbles. It also supports run/halt/single-step debug control and an optional return-address stack. It sits between the hazard/execute logic and the PC, alongside the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_ras.sv | 54 +++++
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: state encoding, default PC width and
// a saturating increment used by the performance counters.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_BUBBLE = 3'd2,
        ST_HALTED = 3'd3,
        ST_STEP   = 3'd4
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_val) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty leaves state untouched and the caller treats it as underflow.
module fetch_ras
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [PTR_W:0]    count;

    logic do_pop;
    logic do_push;

    // Pop has priority; a simultaneous push is dropped by the caller anyway.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
        end else if (do_pop) begin
            sp    <= sp - PTR_W'(1);
            count <= count - (PTR_W+1)'(1);
        end else if (do_push) begin
            sp <= sp + PTR_W'(1);
            if (count != (PTR_W+1)'(DEPTH))
                count <= count + (PTR_W+1)'(1);
        end
    end

    // Storage is left unreset so it can map onto plain registers or LUT RAM.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[sp] <= push_data;
    end

    assign top   = mem[sp - PTR_W'(1)];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller driving the PC inc/branch/halt controls.
// Optional return-address stack enabled with `define FETCH_RAS_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned BR_PENALTY = 1,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall_req,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              call_req,
    input  logic [ADDR_W-1:0] link_addr,
    input  logic              ret_req,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              step,
    output logic              pc_inc,
    output logic              pc_branch_en,
    output logic              pc_halt,
    output logic [ADDR_W-1:0] pc_branch_addr,
    output logic              if_valid,
    output logic              flush,
    output logic [2:0]        state_o,
    output logic              ras_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    state_t     state;
    logic [2:0] bub_cnt;

    logic redir_req;
    logic redir_ev;
    logic stall_ev;

    assign redir_req = br_req || ret_req;
    assign state_o   = state;

    // Mealy control decode: registered state plus current requests.
    always_comb begin
        pc_inc       = 1'b0;
        pc_branch_en = 1'b0;
        pc_halt      = 1'b0;
        if_valid     = 1'b0;
        flush        = 1'b0;
        redir_ev     = 1'b0;
        stall_ev     = 1'b0;
        case (state)
            ST_RUN, ST_STEP: begin
                if (halt_req) begin
                    pc_halt = 1'b1;
                    flush   = 1'b1;
                end else if (redir_req) begin
                    pc_branch_en = 1'b1;
                    flush        = 1'b1;
                    redir_ev     = 1'b1;
                end else if (stall_req && state == ST_RUN) begin
                    pc_halt  = 1'b1;
                    stall_ev = 1'b1;
                end else begin
                    pc_inc   = 1'b1;
                    if_valid = 1'b1;
                end
            end
            default: pc_halt = 1'b1;
        endcase
    end

`ifdef FETCH_RAS_EN
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_push;
    logic              ras_pop;

    assign ras_pop  = redir_ev && ret_req;
    assign ras_push = redir_ev && br_req && call_req && !ret_req;

    fetch_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_addr),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_comb begin
        pc_branch_addr = '0;
        if (pc_branch_en) begin
            if (ret_req)
                pc_branch_addr = ras_empty ? '0 : ras_top;
            else
                pc_branch_addr = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ras_err <= 1'b0;
        else if (ras_pop && ras_empty)
            ras_err <= 1'b1;
    end
`else
    logic unused_ras_inputs;
    localparam int unsigned unused_ras_depth = RAS_DEPTH;

    assign unused_ras_inputs = &{1'b0, call_req, link_addr};
    assign pc_branch_addr    = pc_branch_en ? br_target : '0;
    assign ras_err           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bub_cnt      <= '0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall_ev)
                stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), CNT_W));
            if (redir_ev)
                redirect_cnt <= CNT_W'(sat_inc(32'(redirect_cnt), CNT_W));

            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state <= ST_HALTED;
                    end else if (redir_req && BR_PENALTY != 0) begin
                        state   <= ST_BUBBLE;
                        bub_cnt <= 3'(BR_PENALTY - 1);
                    end
                end
                ST_BUBBLE: begin
                    if (bub_cnt == '0)
                        state <= ST_RUN;
                    else
                        bub_cnt <= bub_cnt - 3'd1;
                end
                ST_HALTED: begin
                    if (resume)
                        state <= ST_RUN;
                    else if (step)
                        state <= ST_STEP;
                end
                ST_STEP:  state <= ST_HALTED;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
